mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-002 The block SHALL have port mduStart, input, 1 bit: one-cycle request qualifying mduOp.
REQ-003 The block SHALL have port mduOp, input, 3 bits: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
REQ-004 The block SHALL have port mduA, input, 32 bits: operand A (rs), from the register-file read port 1.
REQ-005 The block SHALL have port mduB, input, 32 bits: operand B (rt), from the register-file read port 2.
REQ-006 The block SHALL have port mduHi, output, 32 bits: HI register contents.
REQ-007 The block SHALL have port mduLo, output, 32 bits: LO register contents.
REQ-008 The block SHALL have port mduBusy, output, 1 bit: high while an operation is in flight.

Function
REQ-009 States SHALL be IDLE and BUSY, plus a cycle counter; mduBusy SHALL equal (state==BUSY), driven from a register.
REQ-010 In IDLE, at an edge with mduStart=1 and mduOp in 1..4, mduA and mduB SHALL be latched internally, the counter SHALL be loaded, and the state SHALL become BUSY.
REQ-011 Latency SHALL be 5 cycles for MULT/MULTU and 10 cycles for DIV/DIVU: a start sampled at edge k SHALL give mduBusy=1 after edges k..k+N-1, with HI/LO written and mduBusy=0 at edge k+N.
REQ-012 Results SHALL depend only on the latched operands; changes to mduA/mduB while BUSY SHALL have no effect.
REQ-013 MULT SHALL compute the signed 64-bit product and MULTU the unsigned 64-bit product, with {HI,LO} = product.
REQ-014 DIV SHALL compute the signed quotient truncated toward zero into LO and the remainder into HI; the remainder SHALL carry the sign of the dividend.
REQ-015 DIVU SHALL compute the unsigned quotient into LO and the unsigned remainder into HI.
REQ-016 DIV with 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000.
REQ-017 Divide by zero (DIV or DIVU with mduB=0) SHALL still hold mduBusy for 10 cycles and SHALL leave HI/LO unchanged.
REQ-018 MTHI/MTLO with mduStart=1 in IDLE SHALL write mduA to HI/LO at that edge with no busy cycle, visible on the output the next cycle.
REQ-019 mduStart=1 while BUSY SHALL be ignored entirely (no restart, no MTHI/MTLO write, no queuing).
REQ-020 A start with mduOp 0 or 7 SHALL be a no-op; mduOp SHALL be ignored when mduStart=0.
REQ-021 The start of the next operation SHALL be accepted at the edge immediately after mduBusy falls (back-to-back, no bubble is required).

Reset
REQ-022 With reset=1 at an edge, HI, LO, the counter and the latched operands SHALL clear to 0 and the state SHALL become IDLE (mduBusy=0), overriding mduStart.
REQ-023 A reset mid-operation SHALL abort the operation; no result SHALL be written afterwards.

Configuration
REQ-024 When the macro MDU_DIV_EN is defined, DIV/DIVU SHALL behave per REQ-011 and REQ-014 to REQ-017.
REQ-025 When MDU_DIV_EN is undefined, the divider logic SHALL be absent, and DIV/DIVU starts SHALL be no-ops (no busy, HI/LO unchanged); multiply and move behaviour SHALL be identical in both builds.

Verification
REQ-026 The bench SHALL cover MULT: reset, then MULT with A=0xFFFFFFFE (-2), B=0x00000003 -> mduBusy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-027 The bench SHALL cover MULTU: MULTU with A=0xFFFFFFFF, B=0x00000002 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-028 The bench SHALL cover DIV: DIV with A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU with A=7, B=0 -> busy for 10 cycles, HI/LO unchanged.
REQ-029 The bench SHALL cover moves during and after BUSY: MTHI with A=0x12345678 while BUSY -> HI unaffected; the same MTHI in IDLE -> HI=0x12345678 next cycle, mduBusy stays 0.
REQ-030 The bench SHALL cover reset mid-operation: MULT 3x4, reset asserted on cycle 3 -> HI=LO=0, mduBusy=0, no later write; a new MULT 3x4 afterwards -> LO=0x0000000C.
REQ-031 The bench SHALL cover the build without MDU_DIV_EN: DIV 8/2 -> mduBusy stays 0, HI/LO keep their prior values.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS-style HI/LO unit: MULT/MULTU (5 cycles), DIV/DIVU (10 cycles), MTHI/MTLO (immediate).
// Starts are ignored while busy; the divider exists only when MDU_DIV_EN is defined.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        mduStart,
    input  logic [2:0]  mduOp,
    input  logic [31:0] mduA,
    input  logic [31:0] mduB,
    output logic [31:0] mduHi,
    output logic [31:0] mduLo,
    output logic        mduBusy
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] a_q, a_nxt, b_q, b_nxt;
    logic [2:0]  op_q, op_nxt;
    logic [31:0] hi, hi_nxt, lo, lo_nxt;

    logic        start_mul, start_div, op_is_mul;
    logic [63:0] a_ext, b_ext, product;

    assign start_mul = (mduOp == OP_MULT) || (mduOp == OP_MULTU);
    assign op_is_mul = (op_q == OP_MULT) || (op_q == OP_MULTU);

    // Sign-extend for MULT; the low 64 bits of the product are then exact.
    assign a_ext   = {{32{(op_q == OP_MULT) & a_q[31]}}, a_q};
    assign b_ext   = {{32{(op_q == OP_MULT) & b_q[31]}}, b_q};
    assign product = a_ext * b_ext;

`ifdef MDU_DIV_EN
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    assign start_div = (mduOp == OP_DIV) || (mduOp == OP_DIVU);
    // Divide magnitudes unsigned so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign a_neg = (op_q == OP_DIV) & a_q[31];
    assign b_neg = (op_q == OP_DIV) & b_q[31];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem   = a_neg ? -r_mag : r_mag;
`else
    assign start_div = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        a_nxt     = a_q;
        b_nxt     = b_q;
        op_nxt    = op_q;
        hi_nxt    = hi;
        lo_nxt    = lo;
        case (state)
            IDLE: begin
                if (mduStart) begin
                    if (start_mul || start_div) begin
                        a_nxt     = mduA;
                        b_nxt     = mduB;
                        op_nxt    = mduOp;
                        cnt_nxt   = start_mul ? 4'd4 : 4'd9;
                        state_nxt = BUSY;
                    end else if (mduOp == OP_MTHI) begin
                        hi_nxt = mduA;
                    end else if (mduOp == OP_MTLO) begin
                        lo_nxt = mduA;
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                    if (op_is_mul) begin
                        hi_nxt = product[63:32];
                        lo_nxt = product[31:0];
                    end
`ifdef MDU_DIV_EN
                    else if (b_q != 32'd0) begin
                        hi_nxt = rem;
                        lo_nxt = quot;
                    end
`endif
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            op_q  <= 3'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            op_q  <= op_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
        end
    end

    assign mduHi   = hi;
    assign mduLo   = lo;
    assign mduBusy = (state == BUSY);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: inputs change and outputs are sampled on the falling edge.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mduStart;
    logic [2:0]  mduOp;
    logic [31:0] mduA, mduB;
    logic [31:0] mduHi, mduLo;
    logic        mduBusy;

    int vectors = 0;
    int miscompares = 0;

    mul_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .mduStart (mduStart),
        .mduOp    (mduOp),
        .mduA     (mduA),
        .mduB     (mduB),
        .mduHi    (mduHi),
        .mduLo    (mduLo),
        .mduBusy  (mduBusy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where busy has just dropped.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] ehi, input logic [31:0] elo);
        mduStart = 1'b1; mduOp = op; mduA = a; mduB = b;
        @(negedge clk);
        mduStart = 1'b0; mduOp = 3'd0;
        check({tag, " busy c1"}, {31'd0, mduBusy}, 32'd1);
        for (int i = 1; i < n; i++) begin
            mduA = $urandom; mduB = $urandom;
            @(negedge clk);
            check({tag, " busy"}, {31'd0, mduBusy}, 32'd1);
        end
        @(negedge clk);
        check({tag, " done"}, {31'd0, mduBusy}, 32'd0);
        check({tag, " hi"}, mduHi, ehi);
        check({tag, " lo"}, mduLo, elo);
    endtask

    initial begin
        reset = 1'b1; mduStart = 1'b1; mduOp = 3'd1; mduA = 32'h5; mduB = 32'h7;
        repeat (2) @(negedge clk);
        reset = 1'b0; mduStart = 1'b0; mduOp = 3'd0;
        check("reset busy", {31'd0, mduBusy}, 32'd0);
        check("reset hi", mduHi, 32'h0);
        check("reset lo", mduLo, 32'h0);

        run_op("mult -2*3", 3'd1, 32'hFFFFFFFE, 32'h3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        // Issued at the same falling edge busy dropped: accepted back-to-back.
        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'h2, 5, 32'h00000001, 32'hFFFFFFFE);

        // MTHI while busy must be dropped.
        mduStart = 1'b1; mduOp = 3'd1; mduA = 32'd3; mduB = 32'd4;
        @(negedge clk);
        check("mthi-busy busy", {31'd0, mduBusy}, 32'd1);
        mduStart = 1'b1; mduOp = 3'd5; mduA = 32'h12345678;
        @(negedge clk);
        mduStart = 1'b0; mduOp = 3'd0;
        check("mthi-busy hi", mduHi, 32'h00000001);
        repeat (3) @(negedge clk);
        check("mthi-busy still busy", {31'd0, mduBusy}, 32'd1);
        @(negedge clk);
        check("mult 3*4 idle", {31'd0, mduBusy}, 32'd0);
        check("mult 3*4 hi", mduHi, 32'h0);
        check("mult 3*4 lo", mduLo, 32'h0000000C);

        mduStart = 1'b1; mduOp = 3'd5; mduA = 32'h12345678;
        @(negedge clk);
        mduStart = 1'b0;
        check("mthi hi", mduHi, 32'h12345678);
        check("mthi busy", {31'd0, mduBusy}, 32'd0);
        mduStart = 1'b1; mduOp = 3'd6; mduA = 32'hCAFEF00D;
        @(negedge clk);
        mduStart = 1'b0;
        check("mtlo lo", mduLo, 32'hCAFEF00D);
        check("mtlo hi kept", mduHi, 32'h12345678);

        // No-op opcodes, and a MULT opcode without start.
        mduStart = 1'b1; mduOp = 3'd0; mduA = 32'h1;
        @(negedge clk);
        mduOp = 3'd7;
        @(negedge clk);
        mduStart = 1'b0; mduOp = 3'd1;
        @(negedge clk);
        mduOp = 3'd0;
        check("noop busy", {31'd0, mduBusy}, 32'd0);
        check("noop hi", mduHi, 32'h12345678);
        check("noop lo", mduLo, 32'hCAFEF00D);

`ifdef MDU_DIV_EN
        run_op("div -7/2", 3'd3, 32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu 7/0", 3'd4, 32'h7, 32'h0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
        run_op("divu 100/7", 3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("div 7/-2", 3'd3, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);
`else
        mduStart = 1'b1; mduOp = 3'd3; mduA = 32'd8; mduB = 32'd2;
        @(negedge clk);
        mduOp = 3'd4;
        @(negedge clk);
        mduStart = 1'b0; mduOp = 3'd0;
        check("nodiv busy", {31'd0, mduBusy}, 32'd0);
        repeat (10) @(negedge clk);
        check("nodiv busy later", {31'd0, mduBusy}, 32'd0);
        check("nodiv hi", mduHi, 32'h12345678);
        check("nodiv lo", mduLo, 32'hCAFEF00D);
`endif

        // Reset on the third cycle of a MULT aborts it.
        mduStart = 1'b1; mduOp = 3'd1; mduA = 32'd3; mduB = 32'd4;
        @(negedge clk);
        mduStart = 1'b0; mduOp = 3'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", {31'd0, mduBusy}, 32'd0);
        check("abort hi", mduHi, 32'h0);
        check("abort lo", mduLo, 32'h0);
        repeat (8) @(negedge clk);
        check("abort late busy", {31'd0, mduBusy}, 32'd0);
        check("abort late hi", mduHi, 32'h0);
        check("abort late lo", mduLo, 32'h0);
        run_op("mult after reset", 3'd1, 32'd3, 32'd4, 5, 32'h0, 32'h0000000C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
